// File: rtl/tlp_xcvr_pkg.sv
// rtl/tlp_xcvr_pkg.sv - shared types for the TLP transceiver blocks
package tlp_xcvr_pkg;

    typedef logic [63:0] uint64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CPL,
        S_F2C
    } ArbState;

    typedef enum logic {
        SRC_CPL,
        SRC_F2C
    } Source;

    typedef struct packed {
        uint64 data;
        logic  sop;
        logic  eop;
    } TxBeat;

endpackage

// File: rtl/tlp_tx_stage.sv
// rtl/tlp_tx_stage.sv - single-entry registered valid/ready output stage
module tlp_tx_stage
    import tlp_xcvr_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  TxBeat beat_in,
    input  logic  ready,
    output logic  free,
    output logic  valid,
    output TxBeat beat_out
);

    assign free = !valid | ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            beat_out <= '0;
        end else if (load) begin
            valid    <= 1'b1;
            beat_out <= beat_in;
        end else if (ready) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/tlp_tx_arb.sv
// rtl/tlp_tx_arb.sv - packet-atomic round-robin arbiter for the PCIe TX port
module tlp_tx_arb
    import tlp_xcvr_pkg::*;
#(
    parameter int MAX_BEATS = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 pcieClk_in,
    input  logic                 pcieRstN_in,
    input  logic [63:0]          cplData_in,
    input  logic                 cplValid_in,
    output logic                 cplReady_out,
    input  logic                 cplSOP_in,
    input  logic                 cplEOP_in,
    input  logic [63:0]          f2cData_in,
    input  logic                 f2cValid_in,
    output logic                 f2cReady_out,
    input  logic                 f2cSOP_in,
    input  logic                 f2cEOP_in,
    output logic [63:0]          txData_out,
    output logic                 txValid_out,
    input  logic                 txReady_in,
    output logic                 txSOP_out,
    output logic                 txEOP_out,
    output logic [CNT_WIDTH-1:0] cplCount_out,
    output logic [CNT_WIDTH-1:0] f2cCount_out,
    output logic                 protoErr_out
);

    localparam int BW = $clog2(MAX_BEATS + 2);

    ArbState        state, state_nx;
    Source          last_grant, last_nx;
    logic [BW-1:0]  beat_cnt, beat_nx, beat_inc;
    logic           stage_free;
    logic           load;
    TxBeat          load_beat, out_beat;
    logic           own_en, own_f2c, own_acc;
    logic           own_valid, own_sop, own_eop;
    uint64          own_data;
    logic           drop_cpl, drop_f2c;
    logic           cpl_rdy, f2c_rdy;
    logic           err_set, cpl_inc, f2c_inc;

    tlp_tx_stage u_stage (
        .clk      (pcieClk_in),
        .rst_n    (pcieRstN_in),
        .load     (load),
        .beat_in  (load_beat),
        .ready    (txReady_in),
        .free     (stage_free),
        .valid    (txValid_out),
        .beat_out (out_beat)
    );

    assign txData_out = out_beat.data;
    assign txSOP_out  = out_beat.sop;
    assign txEOP_out  = out_beat.eop;

    // Readys are forced low while reset is held so no beat is taken mid-reset.
    assign cplReady_out = cpl_rdy & pcieRstN_in;
    assign f2cReady_out = f2c_rdy & pcieRstN_in;

    always_comb begin
        state_nx  = state;
        last_nx   = last_grant;
        beat_nx   = beat_cnt;
        own_en    = 1'b0;
        own_f2c   = (state == S_F2C);
        drop_cpl  = 1'b0;
        drop_f2c  = 1'b0;
        err_set   = 1'b0;
        cpl_inc   = 1'b0;
        f2c_inc   = 1'b0;
        load      = 1'b0;

        case (state)
            S_IDLE: begin
                if (cplValid_in && cplSOP_in &&
                    (!(f2cValid_in && f2cSOP_in) || last_grant == SRC_F2C)) begin
                    own_en  = 1'b1;
                    own_f2c = 1'b0;
                end else if (f2cValid_in && f2cSOP_in) begin
                    own_en  = 1'b1;
                    own_f2c = 1'b1;
                end else if (cplValid_in) begin
                    drop_cpl = 1'b1;
                end else if (f2cValid_in) begin
                    drop_f2c = 1'b1;
                end
            end
            S_CPL, S_F2C: own_en = 1'b1;
            default: own_en = 1'b0;
        endcase

        own_valid = own_f2c ? f2cValid_in : cplValid_in;
        own_sop   = own_f2c ? f2cSOP_in   : cplSOP_in;
        own_eop   = own_f2c ? f2cEOP_in   : cplEOP_in;
        own_data  = own_f2c ? f2cData_in  : cplData_in;
        own_acc   = own_en & own_valid & stage_free;

        cpl_rdy   = (own_en & !own_f2c & stage_free) | drop_cpl;
        f2c_rdy   = (own_en &  own_f2c & stage_free) | drop_f2c;
        load_beat = '{data: own_data, sop: own_sop, eop: own_eop};

        // Saturate so an overlong packet cannot wrap back into the legal range.
        beat_inc = (beat_cnt == BW'(MAX_BEATS + 1)) ? beat_cnt : beat_cnt + BW'(1);

        if (drop_cpl || drop_f2c)
            err_set = 1'b1;

        if (own_acc) begin
            load = 1'b1;
            if (state != S_IDLE && own_sop)
                err_set = 1'b1;
            if (beat_inc > BW'(MAX_BEATS))
                err_set = 1'b1;
            if (own_eop) begin
                state_nx = S_IDLE;
                last_nx  = own_f2c ? SRC_F2C : SRC_CPL;
                beat_nx  = '0;
                cpl_inc  = !own_f2c;
                f2c_inc  = own_f2c;
            end else begin
                state_nx = own_f2c ? S_F2C : S_CPL;
                beat_nx  = beat_inc;
            end
        end
    end

    always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
        if (!pcieRstN_in) begin
            state        <= S_IDLE;
            last_grant   <= SRC_F2C;
            beat_cnt     <= '0;
            cplCount_out <= '0;
            f2cCount_out <= '0;
            protoErr_out <= 1'b0;
        end else begin
            state      <= state_nx;
            last_grant <= last_nx;
            beat_cnt   <= beat_nx;
            if (cpl_inc)
                cplCount_out <= cplCount_out + CNT_WIDTH'(1);
            if (f2c_inc)
                f2cCount_out <= f2cCount_out + CNT_WIDTH'(1);
            if (err_set)
                protoErr_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tlp_tx_arb.sv
// tb/tb_tlp_tx_arb.sv - directed self-checking bench for tlp_tx_arb
module tb_tlp_tx_arb;
    import tlp_xcvr_pkg::*;

    logic        pcieClk_in;
    logic        pcieRstN_in;
    logic [63:0] cplData_in;
    logic        cplValid_in;
    logic        cplReady_out;
    logic        cplSOP_in;
    logic        cplEOP_in;
    logic [63:0] f2cData_in;
    logic        f2cValid_in;
    logic        f2cReady_out;
    logic        f2cSOP_in;
    logic        f2cEOP_in;
    logic [63:0] txData_out;
    logic        txValid_out;
    logic        txReady_in;
    logic        txSOP_out;
    logic        txEOP_out;
    logic [15:0] cplCount_out;
    logic [15:0] f2cCount_out;
    logic        protoErr_out;

    int tests = 0;
    int fails = 0;

    int cpl_len, cpl_npk, cpl_pkt, cpl_beat;
    int f2c_len, f2c_npk, f2c_pkt, f2c_beat;
    int both_rdy, stall_bad, first_cap, last_cap;
    logic [65:0] got[$];
    logic [65:0] exp[$];

    tlp_tx_arb #(.MAX_BEATS(64), .CNT_WIDTH(16)) dut (
        .pcieClk_in   (pcieClk_in),
        .pcieRstN_in  (pcieRstN_in),
        .cplData_in   (cplData_in),
        .cplValid_in  (cplValid_in),
        .cplReady_out (cplReady_out),
        .cplSOP_in    (cplSOP_in),
        .cplEOP_in    (cplEOP_in),
        .f2cData_in   (f2cData_in),
        .f2cValid_in  (f2cValid_in),
        .f2cReady_out (f2cReady_out),
        .f2cSOP_in    (f2cSOP_in),
        .f2cEOP_in    (f2cEOP_in),
        .txData_out   (txData_out),
        .txValid_out  (txValid_out),
        .txReady_in   (txReady_in),
        .txSOP_out    (txSOP_out),
        .txEOP_out    (txEOP_out),
        .cplCount_out (cplCount_out),
        .f2cCount_out (f2cCount_out),
        .protoErr_out (protoErr_out)
    );

    initial pcieClk_in = 1'b0;
    always #5 pcieClk_in = ~pcieClk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] bdata(input logic f, input int p, input int b);
        return (f ? 64'hF200_0000_0000_0000 : 64'hC100_0000_0000_0000)
               | (64'(p) << 32) | 64'(b);
    endfunction

    task automatic add_exp(input logic f, input int p, input int len);
        for (int b = 0; b < len; b++)
            exp.push_back({(b == 0), (b == len - 1), bdata(f, p, b)});
    endtask

    task automatic idle_inputs();
        cplValid_in = 0; cplSOP_in = 0; cplEOP_in = 0; cplData_in = '0;
        f2cValid_in = 0; f2cSOP_in = 0; f2cEOP_in = 0; f2cData_in = '0;
        txReady_in  = 1;
    endtask

    // Leaves the bench at posedge+1 with reset released.
    task automatic do_reset();
        pcieRstN_in = 0;
        idle_inputs();
        repeat (2) @(posedge pcieClk_in);
        @(negedge pcieClk_in);
        pcieRstN_in = 1;
        @(posedge pcieClk_in);
        #1;
    endtask

    task automatic src_init(input int cl, input int cn, input int fl, input int fn);
        cpl_len = cl; cpl_npk = cn; cpl_pkt = 0; cpl_beat = 0;
        f2c_len = fl; f2c_npk = fn; f2c_pkt = 0; f2c_beat = 0;
        both_rdy = 0; stall_bad = 0; first_cap = -1; last_cap = -1;
        got.delete();
        exp.delete();
    endtask

    // Per cycle: drive sources at posedge+1, sample at negedge, advance on accept.
    task automatic run(input int ncyc, input int slo, input int shi);
        logic ca, fa, held_ok;
        logic [65:0] held;
        held_ok = 0;
        held = '0;
        for (int c = 0; c < ncyc; c++) begin
            cplValid_in = (cpl_pkt < cpl_npk);
            cplSOP_in   = cplValid_in && (cpl_beat == 0);
            cplEOP_in   = cplValid_in && (cpl_beat == cpl_len - 1);
            cplData_in  = cplValid_in ? bdata(1'b0, cpl_pkt, cpl_beat) : '0;
            f2cValid_in = (f2c_pkt < f2c_npk);
            f2cSOP_in   = f2cValid_in && (f2c_beat == 0);
            f2cEOP_in   = f2cValid_in && (f2c_beat == f2c_len - 1);
            f2cData_in  = f2cValid_in ? bdata(1'b1, f2c_pkt, f2c_beat) : '0;
            txReady_in  = !(c >= slo && c < shi);
            @(negedge pcieClk_in);
            ca = cplValid_in & cplReady_out;
            fa = f2cValid_in & f2cReady_out;
            if (cplReady_out && f2cReady_out) both_rdy++;
            if (!txReady_in) begin
                if (cplReady_out || f2cReady_out) stall_bad++;
                if (held_ok && ({txSOP_out, txEOP_out, txData_out} !== held)) stall_bad++;
                if (!txValid_out) stall_bad++;
                held = {txSOP_out, txEOP_out, txData_out};
                held_ok = 1;
            end else begin
                held_ok = 0;
            end
            if (txValid_out && txReady_in) begin
                got.push_back({txSOP_out, txEOP_out, txData_out});
                if (first_cap < 0) first_cap = c;
                last_cap = c;
            end
            @(posedge pcieClk_in);
            #1;
            if (ca) begin
                cpl_beat++;
                if (cpl_beat == cpl_len) begin cpl_beat = 0; cpl_pkt++; end
            end
            if (fa) begin
                f2c_beat++;
                if (f2c_beat == f2c_len) begin f2c_beat = 0; f2c_pkt++; end
            end
        end
        idle_inputs();
    endtask

    task automatic cmp_stream(input string tag);
        int mism;
        int n;
        mism = 0;
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        chk({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < n; i++)
            if (got[i] !== exp[i]) mism++;
        chk({tag, "_order"}, 64'(mism), 64'd0);
        chk({tag, "_onehot_rdy"}, 64'(both_rdy), 64'd0);
    endtask

    initial begin
        pcieRstN_in = 0;
        idle_inputs();
        cplValid_in = 1; cplSOP_in = 1; cplEOP_in = 1;
        #3;
        chk("rst_txvalid", 64'(txValid_out), 64'd0);
        chk("rst_txdata", txData_out, 64'd0);
        chk("rst_cplready", 64'(cplReady_out), 64'd0);
        chk("rst_counts", {32'd0, cplCount_out, f2cCount_out}, 64'd0);
        chk("rst_err", 64'(protoErr_out), 64'd0);
        do_reset();

        // single-beat completion
        cplValid_in = 1; cplSOP_in = 1; cplEOP_in = 1; cplData_in = 64'h1122334455667788;
        @(negedge pcieClk_in);
        chk("t1_cplready", 64'(cplReady_out), 64'd1);
        chk("t1_f2cready", 64'(f2cReady_out), 64'd0);
        chk("t1_txvalid_pre", 64'(txValid_out), 64'd0);
        @(posedge pcieClk_in);
        #1;
        idle_inputs();
        chk("t1_txvalid", 64'(txValid_out), 64'd1);
        chk("t1_sop_eop", {62'd0, txSOP_out, txEOP_out}, 64'd3);
        chk("t1_data", txData_out, 64'h1122334455667788);
        chk("t1_cplcount", 64'(cplCount_out), 64'd1);
        chk("t1_state", 64'(dut.state), 64'(S_IDLE));
        @(posedge pcieClk_in);
        #1;
        chk("t1_txvalid_drop", 64'(txValid_out), 64'd0);

        // simultaneous 3-beat packets: CPL first
        do_reset();
        src_init(3, 1, 3, 1);
        add_exp(1'b0, 0, 3);
        add_exp(1'b1, 0, 3);
        run(10, 99, 99);
        cmp_stream("t2");
        chk("t2_counts", {32'd0, cplCount_out, f2cCount_out}, {32'd0, 16'd1, 16'd1});

        // continuous 2-beat traffic: strict alternation, no bubbles
        do_reset();
        src_init(2, 4, 2, 4);
        for (int p = 0; p < 4; p++) begin
            add_exp(1'b0, p, 2);
            add_exp(1'b1, p, 2);
        end
        run(20, 99, 99);
        cmp_stream("t3");
        chk("t3_span", 64'(last_cap - first_cap), 64'd15);
        chk("t3_counts", {32'd0, cplCount_out, f2cCount_out}, {32'd0, 16'd4, 16'd4});

        // 5-cycle backpressure in the middle of a DMA packet
        do_reset();
        src_init(2, 1, 6, 1);
        add_exp(1'b0, 0, 2);
        add_exp(1'b1, 0, 6);
        run(20, 4, 9);
        cmp_stream("t4");
        chk("t4_stall", 64'(stall_bad), 64'd0);
        chk("t4_counts", {32'd0, cplCount_out, f2cCount_out}, {32'd0, 16'd1, 16'd1});

        // beat without SOP in idle is dropped and flags an error
        do_reset();
        f2cValid_in = 1; f2cSOP_in = 0; f2cEOP_in = 0; f2cData_in = 64'hDEAD;
        @(negedge pcieClk_in);
        chk("t5_drop_ready", 64'(f2cReady_out), 64'd1);
        @(posedge pcieClk_in);
        #1;
        idle_inputs();
        chk("t5_drop_txvalid", 64'(txValid_out), 64'd0);
        chk("t5_drop_err", 64'(protoErr_out), 64'd1);
        @(posedge pcieClk_in);
        #1;
        chk("t5_err_sticky", 64'(protoErr_out), 64'd1);
        chk("t5_drop_count", 64'(f2cCount_out), 64'd0);

        // MAX_BEATS is legal, MAX_BEATS+1 is not, both forwarded intact
        do_reset();
        src_init(1, 0, 64, 1);
        add_exp(1'b1, 0, 64);
        run(70, 999, 999);
        cmp_stream("t5_max");
        chk("t5_max_err", 64'(protoErr_out), 64'd0);
        src_init(1, 0, 65, 1);
        add_exp(1'b1, 0, 65);
        run(70, 999, 999);
        cmp_stream("t5_over");
        chk("t5_over_err", 64'(protoErr_out), 64'd1);
        chk("t5_over_count", 64'(f2cCount_out), 64'd2);

        // asynchronous reset at beat 2 of 4
        do_reset();
        src_init(4, 1, 1, 0);
        run(2, 99, 99);
        cplValid_in = 1; cplSOP_in = 0; cplEOP_in = 0; cplData_in = bdata(1'b0, 0, 2);
        chk("t6_pre_txvalid", 64'(txValid_out), 64'd1);
        #2;
        pcieRstN_in = 0;
        #1;
        chk("t6_txvalid", 64'(txValid_out), 64'd0);
        chk("t6_txdata", txData_out, 64'd0);
        chk("t6_sop_eop", {62'd0, txSOP_out, txEOP_out}, 64'd0);
        chk("t6_readys", {62'd0, cplReady_out, f2cReady_out}, 64'd0);
        do_reset();
        src_init(2, 1, 2, 1);
        add_exp(1'b0, 0, 2);
        add_exp(1'b1, 0, 2);
        run(10, 99, 99);
        cmp_stream("t6_after");
        chk("t6_counts", {32'd0, cplCount_out, f2cCount_out}, {32'd0, 16'd1, 16'd1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
